ctrl_decode_stage: RTL and testbench

//  Registered ARM-subset decode stage: decodes mode/op_code/S/I into EX control, detects RAW/load-use

---
 rtl/ctrl_decode_pkg.sv | 46 ++++
 rtl/ctrl_decode_decode.sv | 80 ++++++++
 rtl/ctrl_decode_stage.sv | 150 +++++++++++++++
 tb/tb_ctrl_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_decode_pkg.sv
// Shared encodings and control bundle for the ARM-subset decode stage.
package ctrl_decode_pkg;

  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  localparam logic [3:0] EX_NOP = 4'b0000;
  localparam logic [3:0] EX_MOV = 4'b0001;
  localparam logic [3:0] EX_MVN = 4'b1001;
  localparam logic [3:0] EX_ADD = 4'b0010;
  localparam logic [3:0] EX_ADC = 4'b0011;
  localparam logic [3:0] EX_SUB = 4'b0100;
  localparam logic [3:0] EX_SBC = 4'b0101;
  localparam logic [3:0] EX_AND = 4'b0110;
  localparam logic [3:0] EX_ORR = 4'b0111;
  localparam logic [3:0] EX_EOR = 4'b1000;
  localparam logic [3:0] EX_CMP = 4'b0100;
  localparam logic [3:0] EX_TST = 4'b0110;
  localparam logic [3:0] EX_LDR = 4'b0010;
  localparam logic [3:0] EX_STR = 4'b0010;

  typedef struct packed {
    logic [3:0] cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       imm;
    logic       b;
    logic       update;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_decode.sv
// Pure combinational instruction decode plus source-register usage flags.
import ctrl_decode_pkg::*;

module ctrl_decode (
  input  logic [1:0] mode,
  input  logic [3:0] op_code,
  input  logic       s_bit,
  input  logic       imm_bit,
  output ctrl_t      ctrl,
  output logic       use_src1,
  output logic       use_src2,
  output logic       src2_is_rd
);

  always_comb begin
    ctrl       = '0;
    use_src1   = 1'b1;
    use_src2   = 1'b0;
    src2_is_rd = 1'b0;
    unique case (mode)
      MODE_MEM: begin
        ctrl.imm = imm_bit;
        if (s_bit) begin
          ctrl.cmd      = EX_LDR;
          ctrl.mem_read = 1'b1;
          ctrl.wb_en    = 1'b1;
        end else begin
          ctrl.cmd       = EX_STR;
          ctrl.mem_write = 1'b1;
          use_src2       = 1'b1;
          src2_is_rd     = 1'b1;
        end
      end
      MODE_ARITH: begin
        ctrl.imm    = imm_bit;
        ctrl.update = s_bit;
        ctrl.wb_en  = 1'b1;
        use_src2    = !imm_bit;
        unique case (op_code)
          OP_MOV: begin
            ctrl.cmd = EX_MOV;
            use_src1 = 1'b0;
          end
          OP_MVN: begin
            ctrl.cmd = EX_MVN;
            use_src1 = 1'b0;
          end
          OP_ADD: ctrl.cmd = EX_ADD;
          OP_ADC: ctrl.cmd = EX_ADC;
          OP_SUB: ctrl.cmd = EX_SUB;
          OP_SBC: ctrl.cmd = EX_SBC;
          OP_AND: ctrl.cmd = EX_AND;
          OP_ORR: ctrl.cmd = EX_ORR;
          OP_EOR: ctrl.cmd = EX_EOR;
          OP_CMP: begin
            ctrl.cmd    = EX_CMP;
            ctrl.wb_en  = 1'b0;
            ctrl.update = 1'b1;
          end
          OP_TST: begin
            ctrl.cmd    = EX_TST;
            ctrl.wb_en  = 1'b0;
            ctrl.update = 1'b1;
          end
          default: begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      MODE_BRANCH: begin
        ctrl.b   = 1'b1;
        ctrl.imm = imm_bit;
        use_src1 = 1'b0;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ID stage: decode, RAW/load-use hazard detection, ID/EX register, stall counter.
import ctrl_decode_pkg::*;

module ctrl_decode_stage #(
  parameter int REG_W  = 4,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             S,
  input  logic             I,
  input  logic [1:0]       mode,
  input  logic [3:0]       op_code,
  input  logic [REG_W-1:0] rn,
  input  logic [REG_W-1:0] rm,
  input  logic [REG_W-1:0] rd,
  input  logic             ex_wb_en,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             stall_in,
  input  logic             flush,
  output logic             hazard,
  output logic             ex_valid,
  output logic [3:0]       EX_command,
  output logic             mem_read,
  output logic             mem_write,
  output logic             WB_en,
  output logic             Imm,
  output logic             B,
  output logic             update,
  output logic [REG_W-1:0] ex_src1,
  output logic [REG_W-1:0] ex_src2,
  output logic [REG_W-1:0] ex_rd,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_t            dec_ctrl;
  logic             use_src1;
  logic             use_src2;
  logic             src2_is_rd;
  logic [REG_W-1:0] src2_idx;
  logic             ex_hit;
  logic             mem_hit;

  ctrl_decode u_decode (
    .mode       (mode),
    .op_code    (op_code),
    .s_bit      (S),
    .imm_bit    (I),
    .ctrl       (dec_ctrl),
    .use_src1   (use_src1),
    .use_src2   (use_src2),
    .src2_is_rd (src2_is_rd)
  );

  assign src2_idx = src2_is_rd ? rd : rm;

  // With forwarding only a load in EX cannot be bypassed in time.
  assign ex_hit = ex_wb_en && (!FWD_EN || ex_mem_read) &&
                  ((use_src1 && rn == ex_dest) ||
                   (use_src2 && src2_idx == ex_dest));

  assign mem_hit = !FWD_EN && mem_wb_en &&
                   ((use_src1 && rn == mem_dest) ||
                    (use_src2 && src2_idx == mem_dest));

  assign hazard = id_valid && !flush && (ex_hit || mem_hit);

  ctrl_t            ctrl_d,  ctrl_q;
  logic             valid_d, valid_q;
  logic [REG_W-1:0] src1_d,  src1_q;
  logic [REG_W-1:0] src2_d,  src2_q;
  logic [REG_W-1:0] rd_d,    rd_q;
  logic [CNT_W-1:0] cnt_d,   cnt_q;

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      src1_d  = '0;
      src2_d  = '0;
      rd_d    = '0;
    end else if (stall_in) begin
      ctrl_d = ctrl_q;
    end else if (hazard) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      src1_d  = '0;
      src2_d  = '0;
      rd_d    = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (id_valid) begin
      ctrl_d  = dec_ctrl;
      valid_d = 1'b1;
      src1_d  = rn;
      src2_d  = src2_idx;
      rd_d    = rd;
    end else begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      src1_d  = '0;
      src2_d  = '0;
      rd_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign EX_command = ctrl_q.cmd;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign WB_en      = ctrl_q.wb_en;
  assign Imm        = ctrl_q.imm;
  assign B          = ctrl_q.b;
  assign update     = ctrl_q.update;
  assign illegal    = ctrl_q.illegal;
  assign ex_src1    = src1_q;
  assign ex_src2    = src2_q;
  assign ex_rd      = rd_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench: forwarding and non-forwarding instances side by side.
import ctrl_decode_pkg::*;

module tb_ctrl_decode_stage;

  logic       clk = 1'b0;
  logic       rst, id_valid, S, I;
  logic [1:0] mode;
  logic [3:0] op_code, rn, rm, rd;
  logic       ex_wb_en, ex_mem_read, mem_wb_en, stall_in, flush;
  logic [3:0] ex_dest, mem_dest;

  logic       hz [2];
  logic       v  [2];
  logic [3:0] cmd[2];
  logic       mr [2];
  logic       mw [2];
  logic       wb [2];
  logic       im [2];
  logic       bb [2];
  logic       up [2];
  logic       il [2];
  logic [3:0] s1 [2];
  logic [3:0] s2 [2];
  logic [3:0] xrd[2];
  logic [3:0] cnt[2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    ctrl_decode_stage #(
      .REG_W (4),
      .FWD_EN(k == 0 ? 1'b1 : 1'b0),
      .CNT_W (4)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .S          (S),
      .I          (I),
      .mode       (mode),
      .op_code    (op_code),
      .rn         (rn),
      .rm         (rm),
      .rd         (rd),
      .ex_wb_en   (ex_wb_en),
      .ex_mem_read(ex_mem_read),
      .ex_dest    (ex_dest),
      .mem_wb_en  (mem_wb_en),
      .mem_dest   (mem_dest),
      .stall_in   (stall_in),
      .flush      (flush),
      .hazard     (hz[k]),
      .ex_valid   (v[k]),
      .EX_command (cmd[k]),
      .mem_read   (mr[k]),
      .mem_write  (mw[k]),
      .WB_en      (wb[k]),
      .Imm        (im[k]),
      .B          (bb[k]),
      .update     (up[k]),
      .ex_src1    (s1[k]),
      .ex_src2    (s2[k]),
      .ex_rd      (xrd[k]),
      .illegal    (il[k]),
      .stall_cnt  (cnt[k])
    );
  end

  typedef struct packed {
    logic       v;
    logic [3:0] cmd;
    logic       mr, mw, wb, imm, b, upd, ill;
    logic [3:0] s1, s2, rd;
  } exp_t;

  typedef struct packed {
    exp_t       e;
    logic [3:0] cnt;
  } sb_t;

  sb_t  sbq0[$];
  sb_t  sbq1[$];
  exp_t st [2];
  int   mcnt[2];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode();
    exp_t e = '0;
    e.v  = 1'b1;
    e.s1 = rn;
    e.s2 = rm;
    e.rd = rd;
    case (mode)
      2'b01: begin
        e.imm = I;
        if (S) begin
          e.cmd = EX_LDR; e.mr = 1'b1; e.wb = 1'b1;
        end else begin
          e.cmd = EX_STR; e.mw = 1'b1; e.s2 = rd;
        end
      end
      2'b00: begin
        e.imm = I; e.upd = S; e.wb = 1'b1;
        case (op_code)
          4'b1101: e.cmd = EX_MOV;
          4'b1111: e.cmd = EX_MVN;
          4'b0100: e.cmd = EX_ADD;
          4'b0101: e.cmd = EX_ADC;
          4'b0010: e.cmd = EX_SUB;
          4'b0110: e.cmd = EX_SBC;
          4'b0000: e.cmd = EX_AND;
          4'b1100: e.cmd = EX_ORR;
          4'b0001: e.cmd = EX_EOR;
          4'b1010: begin e.cmd = EX_CMP; e.wb = 1'b0; e.upd = 1'b1; end
          4'b1000: begin e.cmd = EX_TST; e.wb = 1'b0; e.upd = 1'b1; end
          default: begin
            e.wb = 1'b0; e.upd = 1'b0; e.imm = 1'b0; e.ill = 1'b1;
          end
        endcase
      end
      2'b10: begin e.b = 1'b1; e.imm = I; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic ref_hazard(input logic fwd);
    logic       u1, u2, eh, mh;
    logic [3:0] idx2;
    u1   = !(mode == 2'b10) &&
           !(mode == 2'b00 && (op_code == 4'b1101 || op_code == 4'b1111));
    u2   = (mode == 2'b00 && !I) || (mode == 2'b01 && !S);
    idx2 = (mode == 2'b01) ? rd : rm;
    eh   = ex_wb_en && (!fwd || ex_mem_read) &&
           ((u1 && rn == ex_dest) || (u2 && idx2 == ex_dest));
    mh   = !fwd && mem_wb_en &&
           ((u1 && rn == mem_dest) || (u2 && idx2 == mem_dest));
    return id_valid && !flush && (eh || mh);
  endfunction

  task automatic step(input string tag);
    logic  h;
    sb_t   got;
    sb_t   want;
    #1;
    for (int k = 0; k < 2; k++) begin
      h = ref_hazard(k == 0);
      chk($sformatf("%s.hz%0d", tag, k), 32'(hz[k]), 32'(h));
      if (rst) begin
        st[k] = '0; mcnt[k] = 0;
      end else if (flush) begin
        st[k] = '0;
      end else if (stall_in) begin
        st[k] = st[k];
      end else if (h) begin
        st[k] = '0;
        if (mcnt[k] < 15) mcnt[k]++;
      end else if (id_valid) begin
        st[k] = ref_decode();
      end else begin
        st[k] = '0;
      end
      want.e   = st[k];
      want.cnt = 4'(mcnt[k]);
      if (k == 0) sbq0.push_back(want);
      else        sbq1.push_back(want);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      got.e   = {v[k], cmd[k], mr[k], mw[k], wb[k], im[k], bb[k],
                 up[k], il[k], s1[k], s2[k], xrd[k]};
      got.cnt = cnt[k];
      want    = (k == 0) ? sbq0.pop_front() : sbq1.pop_front();
      chk($sformatf("%s.ex%0d", tag, k), 32'(got.e), 32'(want.e));
      chk($sformatf("%s.cnt%0d", tag, k), 32'(got.cnt), 32'(want.cnt));
    end
  endtask

  task automatic instr(input logic vld, input logic [1:0] md,
                       input logic [3:0] op, input logic s, input logic i,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d);
    id_valid = vld; mode = md; op_code = op; S = s; I = i;
    rn = a; rm = b; rd = d;
  endtask

  task automatic clr_ctx();
    ex_wb_en = 0; ex_mem_read = 0; ex_dest = 0;
    mem_wb_en = 0; mem_dest = 0; stall_in = 0; flush = 0;
  endtask

  logic [3:0] ops[11];

  initial begin
    ops = '{4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0010, 4'b0110,
            4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000};
    st[0] = '0; st[1] = '0; mcnt[0] = 0; mcnt[1] = 0;
    clr_ctx();
    rst = 1;
    instr(1, 2'b00, 4'b0100, 1, 0, 4'd1, 4'd2, 4'd3);
    step("rst0");
    step("rst1");
    rst = 0;

    instr(1, 2'b00, 4'b0100, 1, 0, 4'd1, 4'd2, 4'd3);
    step("add");

    ex_wb_en = 1; ex_mem_read = 1; ex_dest = 2;
    instr(1, 2'b00, 4'b0100, 0, 0, 4'd2, 4'd4, 4'd6);
    step("ldhz");
    ex_mem_read = 0;
    step("nold");
    clr_ctx();

    mem_wb_en = 1; mem_dest = 5;
    instr(1, 2'b01, 4'b0000, 0, 0, 4'd1, 4'd7, 4'd5);
    step("str");
    instr(1, 2'b00, 4'b0100, 0, 1, 4'd1, 4'd5, 4'd8);
    step("addi");
    clr_ctx();

    instr(1, 2'b00, 4'b0010, 0, 0, 4'd9, 4'd10, 4'd11);
    step("sub");
    stall_in = 1;
    instr(1, 2'b00, 4'b1101, 1, 1, 4'd1, 4'd2, 4'd3);
    step("stl0");
    instr(1, 2'b01, 4'b0000, 1, 0, 4'd4, 4'd5, 4'd6);
    step("stl1");
    ex_wb_en = 1; ex_mem_read = 1; ex_dest = 4;
    step("stlhz");
    stall_in = 0; flush = 1;
    step("flshz");
    clr_ctx();

    instr(1, 2'b00, 4'b0011, 1, 0, 4'd1, 4'd2, 4'd3);
    step("rsb");
    for (int j = 0; j < 11; j++) begin
      instr(1, 2'b00, ops[j], j[0], j[1], 4'(j), 4'(j + 1), 4'(j + 2));
      step($sformatf("op%0d", j));
    end
    instr(1, 2'b00, 4'b1010, 0, 0, 4'd1, 4'd2, 4'd3);
    step("cmp");
    instr(1, 2'b10, 4'b0000, 0, 1, 4'd1, 4'd2, 4'd3);
    step("br");
    instr(1, 2'b11, 4'b0100, 0, 0, 4'd1, 4'd2, 4'd3);
    step("md3");
    instr(0, 2'b00, 4'b0100, 1, 0, 4'd1, 4'd2, 4'd3);
    step("nov");

    for (int j = 0; j < 16 + 3; j++) begin
      ex_wb_en = 1; ex_mem_read = 1; ex_dest = 2;
      instr(1, 2'b00, 4'b0100, 0, 0, 4'd2, 4'd3, 4'd4);
      step("sat");
    end
    clr_ctx();

    instr(1, 2'b01, 4'b0000, 1, 1, 4'd6, 4'd7, 4'd8);
    step("ldr");
    rst = 1;
    step("mrst0");
    step("mrst1");
    rst = 0;
    instr(0, 2'b00, 4'b0000, 0, 0, 4'd0, 4'd0, 4'd0);
    step("idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
